// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared opcodes, forward selects and FSM states for the mini-CPU pipeline controller
//
// Purpose : package mini_cpu_pkg, imported by the controller, its interface
//           and the hazard_detect sub-module.
// Contents: opcode constants, forwarding mux select codes, controller state enum.
package mini_cpu_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_MUL  = 5'h06;
  localparam logic [4:0] OP_LD   = 5'h0C;
  localparam logic [4:0] OP_HALT = 5'h1F;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    MULDLY = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline status / control bundle between datapath and hazard controller
//
// Purpose : groups the ID/EX/MEM status inputs and the stall/flush/forward
//           outputs of pipe_hazard_ctrl.
// Modports: master = datapath side (drives status, receives controls)
//           slave  = controller side (receives status, drives controls)
// Params  : STALL_CNT_W - width of the stall performance counter
interface pipe_hazard_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  import mini_cpu_pkg::*;

  logic                   start;
  logic [2:0]             rs1_id;
  logic [2:0]             rs2_id;
  logic                   use_rs1_id;
  logic                   use_rs2_id;
  logic [4:0]             op_ex;
  logic [2:0]             rd_ex;
  logic                   we_rf_ex;
  logic [2:0]             rd_mem;
  logic                   we_rf_mem;
  logic                   branch_taken_ex;

  logic                   stall_pc;
  logic                   stall_ifid;
  logic                   hold_idex;
  logic                   bubble_idex;
  logic                   flush_ifid;
  logic [1:0]             fwd_rs1;
  logic [1:0]             fwd_rs2;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output start, rs1_id, rs2_id, use_rs1_id, use_rs2_id, op_ex, rd_ex,
           we_rf_ex, rd_mem, we_rf_mem, branch_taken_ex,
    input  stall_pc, stall_ifid, hold_idex, bubble_idex, flush_ifid,
           fwd_rs1, fwd_rs2, halted, stall_cnt
  );

  modport slave (
    input  start, rs1_id, rs2_id, use_rs1_id, use_rs2_id, op_ex, rd_ex,
           we_rf_ex, rd_mem, we_rf_mem, branch_taken_ex,
    output stall_pc, stall_ifid, hold_idex, bubble_idex, flush_ifid,
           fwd_rs1, fwd_rs2, halted, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational register-match, ID hazard and forward-select logic
//
// Purpose : compares the ID source registers against the EX and MEM
//           destinations and decides whether ID must stall and where each
//           operand is sourced from.
// Macro   : MINI_CPU_FWD_EN - when defined, EX/MEM results are forwarded and
//           only a load-use stalls; otherwise any EX/MEM match stalls.
// Ports   : rs1_id/rs2_id/use_rs*_id - ID operands; op_ex/rd_ex/we_rf_ex - EX
//           producer; rd_mem/we_rf_mem - MEM producer; id_hazard - stall ID;
//           fwd_rs1/fwd_rs2 - operand source select.
module hazard_detect
  import mini_cpu_pkg::*;
(
  input  logic [2:0] rs1_id,
  input  logic [2:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  input  logic [4:0] op_ex,
  input  logic [2:0] rd_ex,
  input  logic       we_rf_ex,
  input  logic [2:0] rd_mem,
  input  logic       we_rf_mem,
  output logic       id_hazard,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2
);

  logic ex_m1, ex_m2, mem_m1, mem_m2;

  // No hard-wired zero register: r0 participates in matching like any other.
  assign ex_m1  = we_rf_ex  && (rd_ex  == rs1_id) && use_rs1_id;
  assign ex_m2  = we_rf_ex  && (rd_ex  == rs2_id) && use_rs2_id;
  assign mem_m1 = we_rf_mem && (rd_mem == rs1_id) && use_rs1_id;
  assign mem_m2 = we_rf_mem && (rd_mem == rs2_id) && use_rs2_id;

`ifdef MINI_CPU_FWD_EN
  logic ex_is_ld;
  assign ex_is_ld = (op_ex == OP_LD);

  always_comb begin
    // Load data is not ready until MEM, so an EX-stage load cannot forward.
    id_hazard = (ex_m1 || ex_m2) && ex_is_ld;
    // EX holds the younger value, so it wins over MEM.
    fwd_rs1 = (ex_m1 && !ex_is_ld) ? FWD_EX : (mem_m1 ? FWD_MEM : FWD_RF);
    fwd_rs2 = (ex_m2 && !ex_is_ld) ? FWD_EX : (mem_m2 ? FWD_MEM : FWD_RF);
  end
`else
  logic unused_op_ex;
  assign unused_op_ex = ^op_ex;

  always_comb begin
    id_hazard = ex_m1 || ex_m2 || mem_m1 || mem_m2;
    fwd_rs1   = FWD_RF;
    fwd_rs2   = FWD_RF;
  end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - central pipeline controller: PC/IF/ID/EX stall, bubble, flush, MUL hold, HALT
//
// Purpose : sequences the PC, IF/ID and ID/EX registers of the mini-CPU and
//           keeps a saturating count of stalled cycles.
// Macro   : MINI_CPU_FWD_EN (consumed in hazard_detect) enables forwarding.
// Params  : MUL_LAT (1..15) total EX cycles of a MUL; STALL_CNT_W counter width.
// Ports   : clk, rst (sync active-high); bus - pipe_hazard_ctrl_if.slave.
module pipe_hazard_ctrl
  import mini_cpu_pkg::*;
#(
  parameter int MUL_LAT     = 3,
  parameter int STALL_CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst,
  pipe_hazard_ctrl_if.slave       bus
);

  localparam logic [3:0] MUL_HOLD = 4'(MUL_LAT - 1);

  state_e                 state_q, state_d;
  logic [3:0]             mul_cnt_q, mul_cnt_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic       id_hazard;
  logic [1:0] hd_fwd_rs1, hd_fwd_rs2;
  logic       stall_pc, stall_ifid, hold_idex, bubble_idex, flush_ifid;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       active;

  hazard_detect u_hazard_detect (
    .rs1_id     (bus.rs1_id),
    .rs2_id     (bus.rs2_id),
    .use_rs1_id (bus.use_rs1_id),
    .use_rs2_id (bus.use_rs2_id),
    .op_ex      (bus.op_ex),
    .rd_ex      (bus.rd_ex),
    .we_rf_ex   (bus.we_rf_ex),
    .rd_mem     (bus.rd_mem),
    .we_rf_mem  (bus.we_rf_mem),
    .id_hazard  (id_hazard),
    .fwd_rs1    (hd_fwd_rs1),
    .fwd_rs2    (hd_fwd_rs2)
  );

  assign active = (state_q == RUN) || (state_q == MULDLY);

  always_comb begin
    state_d     = state_q;
    mul_cnt_d   = mul_cnt_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    hold_idex   = 1'b0;
    bubble_idex = 1'b0;
    flush_ifid  = 1'b0;
    fwd_rs1     = active ? hd_fwd_rs1 : FWD_RF;
    fwd_rs2     = active ? hd_fwd_rs2 : FWD_RF;

    unique case (state_q)
      IDLE: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
        if (bus.start) state_d = RUN;
      end
      RUN, MULDLY: begin
        if (state_q == MULDLY && mul_cnt_q > 4'd1) begin
          // MUL still busy in EX: freeze everything upstream.
          hold_idex  = 1'b1;
          stall_pc   = 1'b1;
          stall_ifid = 1'b1;
          mul_cnt_d  = mul_cnt_q - 4'd1;
        end else begin
          // Last MUL cycle behaves as RUN, minus re-launching the MUL hold.
          state_d   = RUN;
          mul_cnt_d = 4'd0;
          if (bus.op_ex == OP_HALT) begin
            state_d     = HALTED;
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (bus.branch_taken_ex) begin
            // Wrong-path instructions in IF/ID and ID are discarded, so any
            // ID hazard is moot.
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end else if (bus.op_ex == OP_MUL && MUL_LAT > 1 && state_q == RUN) begin
            hold_idex  = 1'b1;
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            mul_cnt_d  = MUL_HOLD;
            state_d    = MULDLY;
          end else if (id_hazard) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
          end
        end
      end
      HALTED: begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        bubble_idex = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (active && stall_pc && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mul_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_pc    = stall_pc;
  assign bus.stall_ifid  = stall_ifid;
  assign bus.hold_idex   = hold_idex;
  assign bus.bubble_idex = bubble_idex;
  assign bus.flush_ifid  = flush_ifid;
  assign bus.fwd_rs1     = fwd_rs1;
  assign bus.fwd_rs2     = fwd_rs2;
  assign bus.halted      = (state_q == HALTED);
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed vectors
module tb_pipe_hazard_ctrl;
  import mini_cpu_pkg::*;

`ifdef MINI_CPU_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int N = FWD ? 0 : 1;

  localparam logic [4:0] OP_ADD = 5'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();

  pipe_hazard_ctrl #(.MUL_LAT(3), .STALL_CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [25:0] v;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [25:0] ex(logic sp, logic si, logic h, logic b,
                                     logic f, logic [1:0] f1, logic [1:0] f2,
                                     logic ha, logic [15:0] c);
    return {sp, si, h, b, f, f1, f2, ha, c};
  endfunction

  // Monitor: combinational outputs are stable mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [25:0] act;
      e   = q.pop_front();
      act = {bus.stall_pc, bus.stall_ifid, bus.hold_idex, bus.bubble_idex,
             bus.flush_ifid, bus.fwd_rs1, bus.fwd_rs2, bus.halted, bus.stall_cnt};
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got %h expected %h (sp si hold bub flush f1 f2 halt cnt)",
                 e.name, act, e.v);
      end
    end
  end

  task automatic vec(input string name, input logic r, input logic st,
                     input logic [4:0] op, input logic [2:0] rdex, input logic weex,
                     input logic [2:0] rdmem, input logic wemem,
                     input logic [2:0] rs1, input logic u1,
                     input logic [2:0] rs2, input logic u2,
                     input logic br, input logic [25:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst                 = r;
    bus.start           = st;
    bus.op_ex           = op;
    bus.rd_ex           = rdex;
    bus.we_rf_ex        = weex;
    bus.rd_mem          = rdmem;
    bus.we_rf_mem       = wemem;
    bus.rs1_id          = rs1;
    bus.use_rs1_id      = u1;
    bus.rs2_id          = rs2;
    bus.use_rs2_id      = u2;
    bus.branch_taken_ex = br;
    x.name = name;
    x.v    = e;
    q.push_back(x);
  endtask

  initial begin
    bus.start = 0; bus.op_ex = OP_NOP; bus.rd_ex = 0; bus.we_rf_ex = 0;
    bus.rd_mem = 0; bus.we_rf_mem = 0; bus.rs1_id = 0; bus.use_rs1_id = 0;
    bus.rs2_id = 0; bus.use_rs2_id = 0; bus.branch_taken_ex = 0;
    repeat (2) @(posedge clk);

    //  name          rst st op      rdex we rdm wm rs1 u1 rs2 u2 br   sp si h b f f1 f2 ha cnt
    vec("reset_idle", 0, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,0,0));
    vec("start",      0, 1, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,0,0));
    vec("run_nop",    0, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,0));
    vec("load_use",   0, 0, OP_LD,  3, 1, 0, 0, 3, 1, 0, 0, 0, ex(1,1,0,1,0,0,0,0,0));
    vec("after_ld",   0, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,1));
    vec("fwd_ex",     0, 0, OP_ADD, 2, 1, 0, 0, 0, 0, 2, 1, 0,
        FWD ? ex(0,0,0,0,0,0,2'b01,0,1) : ex(1,1,0,1,0,0,0,0,1));
    vec("fwd_mem",    0, 0, OP_ADD, 5, 0, 2, 1, 0, 0, 2, 1, 0,
        FWD ? ex(0,0,0,0,0,0,2'b10,0,16'(1+N)) : ex(1,1,0,1,0,0,0,0,16'(1+N)));
    vec("fwd_both",   0, 0, OP_ADD, 2, 1, 2, 1, 0, 0, 2, 1, 0,
        FWD ? ex(0,0,0,0,0,0,2'b01,0,16'(1+2*N)) : ex(1,1,0,1,0,0,0,0,16'(1+2*N)));
    vec("mul_start",  0, 0, OP_MUL, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,1,0,0,0,0,0,16'(1+3*N)));
    vec("mul_hold_br",0, 0, OP_MUL, 0, 0, 0, 0, 0, 0, 0, 0, 1, ex(1,1,1,0,0,0,0,0,16'(2+3*N)));
    vec("mul_release",0, 0, OP_MUL, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0,0,0,0,0,0,0,0,16'(3+3*N)));
    vec("br_vs_ldus", 0, 0, OP_LD,  3, 1, 0, 0, 3, 1, 0, 0, 1, ex(0,0,0,1,1,0,0,0,16'(3+3*N)));
    vec("mul2_start", 0, 0, OP_MUL, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,1,0,0,0,0,0,16'(3+3*N)));
    vec("rst_muldly", 1, 0, OP_MUL, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,1,0,0,0,0,0,16'(4+3*N)));
    vec("idle_again", 0, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,0,0));
    vec("start2",     0, 1, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,0,0));
    vec("halt_op",    0, 0, OP_HALT,0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,0,0));
    vec("halted_st",  0, 1, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,1,1));
    vec("halted_hold",0, 0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1,1,0,1,0,0,0,1,1));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 8-bit mini-CPU.
- Sequences the IF/ID and ID/EX pipeline registers and the PC, generating stall, hold, bubble and flush controls.
- Covers: start-up, taken branches, load-use and RAW hazards, multi-cycle MUL occupancy of EX, and HALT.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 3, total cycles a MUL occupies EX (legal 1..15; 1 = single-cycle, never holds)
STALL_CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, leaves IDLE
rs1_id  in  3  ID-stage source reg 1
rs2_id  in  3  ID-stage source reg 2
use_rs1_id  in  1  ID instruction reads rs1
use_rs2_id  in  1  ID instruction reads rs2
op_ex  in  5  opcode currently in ID/EX output
rd_ex  in  3  EX destination reg
we_rf_ex  in  1  EX writes register file
rd_mem  in  3  MEM destination reg
we_rf_mem  in  1  MEM writes register file
branch_taken_ex  in  1  EX resolved taken branch
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID
hold_idex  out  1  hold ID/EX contents
bubble_idex  out  1  load NOP (op=0, we_rf=0, we_ram=0) into ID/EX
flush_ifid  out  1  clear IF/ID to NOP
fwd_rs1  out  2  00 RF, 01 from EX, 10 from MEM
fwd_rs2  out  2  same for rs2
halted  out  1  HALT retired
stall_cnt  out  STALL_CNT_W  saturating count of cycles with stall_pc=1 in RUN/MULDLY

Behaviour:
- Clock and reset: single clock clk; rst synchronous active-high, sampled on posedge clk.
- Reset: state=IDLE, mul_cnt=0, stall_cnt=0, halted=0.
- Output timing: control outputs are combinational from state plus current inputs; they take effect at the same clock edge.
- States:
  - IDLE: stall_pc=stall_ifid=bubble_idex=1, others 0. start -> RUN.
  - RUN, priority high to low:
    1. op_ex==OP_HALT -> next state HALTED; this cycle stall_pc=stall_ifid=bubble_idex=1.
    2. branch_taken_ex -> flush_ifid=1, bubble_idex=1, no stall; overrides any ID hazard.
    3. op_ex==OP_MUL and MUL_LAT>1 -> hold_idex=stall_pc=stall_ifid=1, mul_cnt<=MUL_LAT-1, next state MULDLY.
    4. ID hazard (see below) -> stall_pc=stall_ifid=bubble_idex=1.
  - MULDLY, mul_cnt>1: hold_idex=stall_pc=stall_ifid=1; mul_cnt decrements; branch and hazard logic ignored.
  - MULDLY, mul_cnt==1: evaluated exactly as RUN with rule 3 suppressed; next state RUN (or HALTED/flush per rules). EX occupancy totals exactly MUL_LAT cycles.
  - HALTED: halted=1, stall_pc=stall_ifid=bubble_idex=1. start ignored; exit only via rst.
- Match definitions:
  - EX match: we_rf_ex && rd_ex==rs && use_rs.
  - MEM match: same test using rd_mem / we_rf_mem.
  - All 8 registers are writable; no zero register.
- ID hazard: defined by the optional feature below.
- stall_cnt: increments when stall_pc=1 in RUN or MULDLY; saturates at all-ones; held otherwise.
- Reset mid-MUL or mid-stall: returns to IDLE next edge; pending MUL abandoned, counter cleared.

Optional Feature:
- Macro: MINI_CPU_FWD_EN.
- Defined:
  - ID hazard = EX match with op_ex==OP_LD (load-use, one bubble).
  - fwd_rsN=01 on EX match when op_ex!=OP_LD, else 10 on MEM match, else 00; EX takes priority over MEM.
- Undefined:
  - fwd_rs1=fwd_rs2=00 constantly.
  - ID hazard = any EX match or MEM match, regardless of opcode.

Decomposition:
- Package mini_cpu_pkg holds:
  - opcode constants OP_NOP=5'h00, OP_MUL=5'h06, OP_LD=5'h0C, OP_HALT=5'h1F;
  - fwd select constants FWD_RF/FWD_EX/FWD_MEM;
  - state enum IDLE/RUN/MULDLY/HALTED.
- One sub-module, hazard_detect: combinational match/hazard/forward logic, with the MINI_CPU_FWD_EN split inside it.

Test Plan:
- Reset, then start: after rst, all stalls high in IDLE, stall_cnt=0. start pulse -> next cycle RUN, stall_pc=0.
- Load-use (FWD_EN): op_ex=OP_LD, rd_ex=3, we_rf_ex=1, rs1_id=3, use_rs1_id=1 -> exactly one cycle of stall_pc/bubble_idex; stall_cnt=1.
- Forward: op_ex=ADD, rd_ex=2, rs2_id=2 -> fwd_rs2=01, no stall. Same reg in MEM only -> 10. Both EX and MEM match -> 01. Without macro -> stall, fwd=00.
- MUL with MUL_LAT=3: hold_idex high 2 cycles, released on 3rd. branch_taken_ex during a hold is ignored.
- Branch vs load-use: both at once -> flush_ifid=1, bubble_idex=1, stall_pc=0.
- HALT: op_ex=OP_HALT -> halted=1 next cycle; start ignored. rst during MULDLY (mul_cnt=2) -> IDLE, stall_cnt=0.
